// File: rtl/mprj_io_serial_loader.sv
// mprj_io_serial_loader
// Loads the user-project IO pad configuration chain. For each pad, starting
// with the highest index, it fetches one config word from the config store.
// It shifts that word MSB first into the chain. After the last pad it issues
// one parallel-load strobe, so every pad switches to its new mode together.
module mprj_io_serial_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
    input  logic [CFG_BITS-1:0]         cfg_data,
    output logic                        serial_clock,
    output logic                        serial_data_out,
    output logic                        serial_load
);

    localparam int AW = $clog2(NUM_PADS);
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PW = $clog2(CLK_DIV + 1);

    localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        SETUP,
        CLKHI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [BW-1:0]       bit_idx;
    logic [PW-1:0]       phase;
    logic [CFG_BITS-1:0] shreg;
    logic                phase_end;
    logic [BW-1:0]       bit_next;

    assign phase_end = (phase == PH_LAST);
    assign bit_next  = bit_idx - BW'(1);

    // Holds the word being shifted. It is pure data and needs no reset, because nothing reads it before CAP.
    always_ff @(posedge clock) begin
        if (state == CAP) begin
            shreg <= cfg_data;
        end
    end

    // Sequencer. All outputs are registered. The counters only decrement when nonzero, so they saturate at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cfg_addr        <= PAD_LAST;
            bit_idx         <= '0;
            phase           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Cancel immediately. The chain keeps its old settings because no load strobe is issued.
            state           <= IDLE;
            cfg_addr        <= PAD_LAST;
            bit_idx         <= '0;
            phase           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= REQ;
                        cfg_addr <= PAD_LAST;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    // The store has cfg_addr during this cycle. Its data is valid in CAP.
                    state <= CAP;
                end
                CAP: begin
                    bit_idx         <= BIT_LAST;
                    phase           <= '0;
                    serial_data_out <= cfg_data[CFG_BITS-1];
                    state           <= SETUP;
                end
                SETUP: begin
                    if (phase_end) begin
                        phase        <= '0;
                        serial_clock <= 1'b1;
                        state        <= CLKHI;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                CLKHI: begin
                    if (phase_end) begin
                        phase        <= '0;
                        serial_clock <= 1'b0;
                        if (bit_idx != '0) begin
                            // Data changes on the same edge that lowers serial_clock. This gives a full low phase of setup.
                            bit_idx         <= bit_next;
                            serial_data_out <= shreg[bit_next];
                            state           <= SETUP;
                        end else if (cfg_addr != '0) begin
                            cfg_addr <= cfg_addr - AW'(1);
                            state    <= REQ;
                        end else begin
                            serial_load <= 1'b1;
                            state       <= LOAD;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                LOAD: begin
                    if (phase_end) begin
                        phase       <= '0;
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Bench for mprj_io_serial_loader. It uses two instances: CLK_DIV=1 (index 0)
// and CLK_DIV=3 (index 1). Both have a two-pad, four-bit chain.
// A registered config store model with one cycle of latency feeds each instance.
module tb_mprj_io_serial_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_s [2];
    logic       abort_s [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic [0:0] addr_w  [2];
    logic [3:0] cfg_w   [2];
    logic       sclk_w  [2];
    logic       sdo_w   [2];
    logic       load_w  [2];
    logic [3:0] mem     [2];

    int   total = 0;
    int   bad   = 0;
    logic exp_q [$];

    int   busy_cnt [2];
    int   done_cnt [2];
    int   done_at  [2];
    int   load_cnt [2];
    int   edge_cnt [2];
    int   extra    [2];
    int   hold_bad [2];
    int   phase_bad[2];
    int   hi_run   [2];
    logic sclk_prev[2];
    logic sdo_prev [2];
    logic load_prev[2];

    always #5 clock = ~clock;

    mprj_io_serial_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
        .busy(busy_w[0]), .done(done_w[0]), .cfg_addr(addr_w[0]), .cfg_data(cfg_w[0]),
        .serial_clock(sclk_w[0]), .serial_data_out(sdo_w[0]), .serial_load(load_w[0])
    );

    mprj_io_serial_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3)) dut3 (
        .clock(clock), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
        .busy(busy_w[1]), .done(done_w[1]), .cfg_addr(addr_w[1]), .cfg_data(cfg_w[1]),
        .serial_clock(sclk_w[1]), .serial_data_out(sdo_w[1]), .serial_load(load_w[1])
    );

    // Config store model with a one-cycle read latency.
    always @(posedge clock) begin
        cfg_w[0] <= mem[addr_w[0]];
        cfg_w[1] <= mem[addr_w[1]];
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Chain monitor. It samples on the falling edge of clock.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (busy_w[k]) busy_cnt[k]++;
            if (done_w[k]) begin
                done_cnt[k]++;
                done_at[k] = busy_cnt[k];
            end
            if (load_w[k] && !load_prev[k]) load_cnt[k]++;
            if (sclk_w[k] && !sclk_prev[k]) begin
                edge_cnt[k]++;
                if (exp_q.size() > 0) chk("sdo_bit", int'(sdo_w[k]), int'(exp_q.pop_front()));
                else extra[k]++;
            end
            if (sclk_w[k] && sclk_prev[k] && sdo_w[k] != sdo_prev[k]) hold_bad[k]++;
            if (sclk_w[k]) begin
                hi_run[k]++;
            end else begin
                if (sclk_prev[k] && hi_run[k] != div_of(k)) phase_bad[k]++;
                hi_run[k] = 0;
            end
            sclk_prev[k] = sclk_w[k];
            sdo_prev[k]  = sdo_w[k];
            load_prev[k] = load_w[k];
        end
    end

    task automatic clr(input int k);
        busy_cnt[k] = 0; done_cnt[k] = 0; done_at[k] = 0; load_cnt[k] = 0;
        edge_cnt[k] = 0; extra[k] = 0; hold_bad[k] = 0; phase_bad[k] = 0;
    endtask

    task automatic push_expected();
        logic [7:0] w;
        exp_q.delete();
        w = {mem[1], mem[0]};
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    // Full chain load on instance k. If restart is 1, start is pulsed again during SETUP of pad1 bit2.
    task automatic run_load(input int k, input bit restart);
        int  exp_busy;
        bit  pulsed;
        pulsed   = 1'b0;
        exp_busy = 2 * (2 + 2 * div_of(k) * 4) + div_of(k) + 1;
        clr(k);
        push_expected();
        @(negedge clock); start_s[k] = 1'b1;
        @(negedge clock); start_s[k] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock); #1;
            if (restart && !pulsed && edge_cnt[k] == 1 && !sclk_w[k]) begin
                start_s[k] = 1'b1;
                pulsed     = 1'b1;
            end else begin
                start_s[k] = 1'b0;
            end
            if (!busy_w[k]) break;
        end
        chk("busy_end", int'(busy_w[k]), 0);
        repeat (3) @(negedge clock);
        #1;
        chk("edge_count", edge_cnt[k], 8);
        chk("extra_edges", extra[k], 0);
        chk("bits_left", exp_q.size(), 0);
        chk("load_pulses", load_cnt[k], 1);
        chk("busy_cycles", busy_cnt[k], exp_busy);
        chk("done_pulses", done_cnt[k], 1);
        chk("done_cycle", done_at[k], exp_busy);
        chk("hold_stable", hold_bad[k], 0);
        chk("hi_phase_len", phase_bad[k], 0);
    endtask

    initial begin
        mem[0] = 4'h5;
        mem[1] = 4'hA;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; abort_s[k] = 1'b0;
            sclk_prev[k] = 1'b0; sdo_prev[k] = 1'b0; load_prev[k] = 1'b0; hi_run[k] = 0;
            clr(k);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", int'(busy_w[k]), 0);
            chk("rst_done", int'(done_w[k]), 0);
            chk("rst_sclk", int'(sclk_w[k]), 0);
            chk("rst_sdo", int'(sdo_w[k]), 0);
            chk("rst_load", int'(load_w[k]), 0);
            chk("rst_addr", int'(addr_w[k]), 1);
        end
        @(negedge clock); reset = 1'b0;

        // Basic load with CLK_DIV=1, then with CLK_DIV=3.
        run_load(0, 1'b0);
        run_load(1, 1'b0);

        // A second start pulse in the middle of a load is ignored.
        run_load(0, 1'b1);

        // Abort in CLKHI of pad0 bit1, which is the 7th rising edge.
        clr(0);
        push_expected();
        @(negedge clock); start_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock); #1;
            if (edge_cnt[0] == 7 && sclk_w[0]) break;
        end
        chk("abort_at_edge", edge_cnt[0], 7);
        abort_s[0] = 1'b1;
        @(negedge clock); #1;
        abort_s[0] = 1'b0;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_sclk", int'(sclk_w[0]), 0);
        chk("abort_load", int'(load_w[0]), 0);
        chk("abort_done", int'(done_w[0]), 0);
        chk("abort_addr", int'(addr_w[0]), 1);
        repeat (30) @(negedge clock);
        #1;
        chk("abort_no_load", load_cnt[0], 0);
        chk("abort_no_done", done_cnt[0], 0);
        chk("abort_edges", edge_cnt[0], 7);
        exp_q.delete();

        // Asynchronous reset in the middle of CLKHI.
        clr(0);
        push_expected();
        @(negedge clock); start_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock); #1;
            if (edge_cnt[0] == 3 && sclk_w[0]) break;
        end
        chk("rstmid_sclk_hi", int'(sclk_w[0]), 1);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_sclk", int'(sclk_w[0]), 0);
        chk("rstmid_busy", int'(busy_w[0]), 0);
        chk("rstmid_sdo", int'(sdo_w[0]), 0);
        chk("rstmid_load", int'(load_w[0]), 0);
        chk("rstmid_done", int'(done_w[0]), 0);
        chk("rstmid_addr", int'(addr_w[0]), 1);
        @(negedge clock); reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rstmid_no_load", load_cnt[0], 0);
        run_load(0, 1'b0);

        // start and abort together in IDLE leave the loader idle.
        @(negedge clock); start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0; abort_s[0] = 1'b0;
        #1;
        chk("both_idle_busy", int'(busy_w[0]), 0);
        @(negedge clock); #1;
        chk("both_idle_busy2", int'(busy_w[0]), 0);
        chk("both_idle_sclk", int'(sclk_w[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
